// File: rtl/dl_router.sv
// Routes HPS ioctl download bytes into BIOS, sprite ROM and music buffer through a small FIFO,
// and holds the core in reset across a BIOS load plus a fixed tail.
//
// state | meaning
// IDLE  | no download activity, FIFO drained
// LOAD  | dn_download high, bytes being queued
// DRAIN | download ended, emptying FIFO into targets
// HOLD  | BIOS drained, core_reset held for the tail count
module dl_router #(
  parameter int ADDR_W      = 17,
  parameter int FIFO_DEPTH  = 4,
  parameter int TAIL_CYCLES = 16
) (
  input  logic              clk_24,
  input  logic              reset,
  input  logic              dn_download,
  input  logic              dn_wr,
  input  logic [ADDR_W-1:0] dn_addr,
  input  logic [7:0]        dn_data,
  input  logic [7:0]        dn_index,
  output logic              bios_wr,
  output logic [ADDR_W-1:0] bios_addr,
  output logic [7:0]        bios_data,
  input  logic              bios_ready,
  output logic              sprite_wr,
  output logic [ADDR_W-1:0] sprite_addr,
  output logic [7:0]        sprite_data,
  input  logic              sprite_ready,
  output logic              music_wr,
  output logic [ADDR_W-1:0] music_addr,
  output logic [7:0]        music_data,
  input  logic              music_ready,
  output logic              core_reset,
  output logic              busy,
  output logic              overflow,
  output logic [7:0]        dropped
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = 2 + ADDR_W + 8;
  localparam int TC_W  = $clog2(TAIL_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
  localparam logic [1:0] TGT_BIOS   = 2'd0;
  localparam logic [1:0] TGT_SPRITE = 2'd1;
  localparam logic [1:0] TGT_MUSIC  = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DRAIN, S_HOLD} state_t;

  state_t             state_q, state_d;
  logic [ENT_W-1:0]   mem_q [FIFO_DEPTH];
  logic [ENT_W-1:0]   mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [TC_W-1:0]    hold_cnt_q, hold_cnt_d;
  logic               dl_prev_q, dl_prev_d;
  logic               bios_session_q, bios_session_d;
  logic               core_reset_q, core_reset_d;
  logic               busy_q, busy_d;
  logic               overflow_q, overflow_d;
  logic [7:0]         dropped_q, dropped_d;

  logic [ENT_W-1:0]   head;
  logic [1:0]         head_tgt, in_tgt;
  logic               valid, mapped, push_req, push_ok, stray, pop, rise;
  logic [7:0]         dropped_base;

  assign head     = mem_q[rd_ptr_q];
  assign head_tgt = head[ENT_W-1 -: 2];
  assign valid    = (count_q != '0);
  assign rise     = dn_download & ~dl_prev_q;

  always_comb begin
    mapped = 1'b1;
    in_tgt = TGT_MUSIC;
    case (dn_index)
      8'd0, 8'd1: in_tgt = TGT_BIOS;
      8'd3:       in_tgt = TGT_SPRITE;
      8'd4:       in_tgt = TGT_MUSIC;
      default:    mapped = 1'b0;
    endcase
  end

  assign push_req = dn_wr & dn_download & mapped;
  assign stray    = dn_wr & ~(dn_download & mapped);
  assign pop      = valid & (((head_tgt == TGT_BIOS)   & bios_ready)   |
                             ((head_tgt == TGT_SPRITE) & sprite_ready) |
                             ((head_tgt == TGT_MUSIC)  & music_ready));
  // A full FIFO still takes a byte when the head leaves in the same cycle.
  assign push_ok  = push_req & ((count_q != DEPTH_C) | pop);

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    dl_prev_d  = dn_download;

    if (push_ok) begin
      mem_d[wr_ptr_q] = {in_tgt, dn_addr, dn_data};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE:  if (rise) state_d = S_LOAD;
      S_LOAD:  if (!dn_download) state_d = S_DRAIN;
      S_DRAIN: begin
        if (rise) state_d = S_LOAD;
        else if (!valid) begin
          if (bios_session_q) begin
            state_d    = S_HOLD;
            hold_cnt_d = TC_W'(TAIL_CYCLES - 1);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        if (rise) state_d = S_LOAD;
        else if (hold_cnt_q == '0) state_d = S_IDLE;
        else hold_cnt_d = hold_cnt_q - TC_W'(1);
      end
      default: state_d = S_IDLE;
    endcase

    overflow_d   = (rise ? 1'b0 : overflow_q) | (push_req & ~push_ok);
    dropped_base = rise ? 8'd0 : dropped_q;
    dropped_d    = (stray && dropped_base != 8'hFF) ? dropped_base + 8'd1 : dropped_base;

    // Session flag follows the next state so core_reset lands one cycle after the edge.
    bios_session_d = (state_d == S_IDLE) ? 1'b0
                   : (bios_session_q | (dn_download & (dn_index < 8'd2)));
    core_reset_d   = bios_session_d;
    busy_d         = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_24) begin
    if (reset) begin
      state_q        <= S_IDLE;
      mem_q          <= '{default: '0};
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      hold_cnt_q     <= '0;
      dl_prev_q      <= 1'b0;
      bios_session_q <= 1'b0;
      core_reset_q   <= 1'b0;
      busy_q         <= 1'b0;
      overflow_q     <= 1'b0;
      dropped_q      <= 8'd0;
    end else begin
      state_q        <= state_d;
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      hold_cnt_q     <= hold_cnt_d;
      dl_prev_q      <= dl_prev_d;
      bios_session_q <= bios_session_d;
      core_reset_q   <= core_reset_d;
      busy_q         <= busy_d;
      overflow_q     <= overflow_d;
      dropped_q      <= dropped_d;
    end
  end

  assign bios_wr     = valid & (head_tgt == TGT_BIOS);
  assign sprite_wr   = valid & (head_tgt == TGT_SPRITE);
  assign music_wr    = valid & (head_tgt == TGT_MUSIC);
  assign bios_addr   = head[8 +: ADDR_W];
  assign sprite_addr = head[8 +: ADDR_W];
  assign music_addr  = head[8 +: ADDR_W];
  assign bios_data   = head[7:0];
  assign sprite_data = head[7:0];
  assign music_data  = head[7:0];
  assign core_reset  = core_reset_q;
  assign busy        = busy_q;
  assign overflow    = overflow_q;
  assign dropped     = dropped_q;

endmodule

// File: tb/tb_dl_router.sv
// Scoreboard bench for dl_router: expected bytes are queued as they are driven and
// popped by a negedge monitor whenever a target handshake completes.
module tb_dl_router;
  localparam int ADDR_W = 17;

  typedef struct packed {
    logic [1:0]        tgt;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        data;
  } ent_t;

  logic              clk_24 = 1'b0;
  logic              reset = 1'b1;
  logic              dn_download = 1'b0, dn_wr = 1'b0;
  logic [ADDR_W-1:0] dn_addr = '0;
  logic [7:0]        dn_data = '0, dn_index = '0;
  logic              bios_wr, sprite_wr, music_wr;
  logic [ADDR_W-1:0] bios_addr, sprite_addr, music_addr;
  logic [7:0]        bios_data, sprite_data, music_data;
  logic              bios_ready = 1'b1, sprite_ready = 1'b1, music_ready = 1'b1;
  logic              core_reset, busy, overflow;
  logic [7:0]        dropped;

  int   errors = 0;
  int   checks = 0;
  ent_t sb[$];
  int   xfer_cnt[3] = '{0, 0, 0};
  int   xfer_total = 0;
  logic cr_seen = 1'b0;

  always #5 clk_24 = ~clk_24;

  dl_router #(.ADDR_W(ADDR_W), .FIFO_DEPTH(4), .TAIL_CYCLES(16)) dut (
    .clk_24(clk_24), .reset(reset),
    .dn_download(dn_download), .dn_wr(dn_wr), .dn_addr(dn_addr),
    .dn_data(dn_data), .dn_index(dn_index),
    .bios_wr(bios_wr), .bios_addr(bios_addr), .bios_data(bios_data), .bios_ready(bios_ready),
    .sprite_wr(sprite_wr), .sprite_addr(sprite_addr), .sprite_data(sprite_data),
    .sprite_ready(sprite_ready),
    .music_wr(music_wr), .music_addr(music_addr), .music_data(music_data),
    .music_ready(music_ready),
    .core_reset(core_reset), .busy(busy), .overflow(overflow), .dropped(dropped)
  );

  always @(negedge clk_24) begin : monitor
    ent_t act;
    ent_t exp;
    logic fire;
    fire = 1'b0;
    act  = '0;
    if (core_reset === 1'b1) cr_seen = 1'b1;
    if (bios_wr && bios_ready) begin
      fire = 1'b1; act = '{tgt: 2'd0, addr: bios_addr, data: bios_data};
    end else if (sprite_wr && sprite_ready) begin
      fire = 1'b1; act = '{tgt: 2'd1, addr: sprite_addr, data: sprite_data};
    end else if (music_wr && music_ready) begin
      fire = 1'b1; act = '{tgt: 2'd2, addr: music_addr, data: music_data};
    end
    checks++;
    if ((int'(bios_wr) + int'(sprite_wr) + int'(music_wr)) > 1) begin
      errors++;
      $display("FAIL wr_onehot: got bios/sprite/music wr=%b%b%b, required at most one",
               bios_wr, sprite_wr, music_wr);
    end
    if (fire) begin
      checks++;
      xfer_total++;
      if (act.tgt < 2'd3) xfer_cnt[act.tgt]++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL xfer_unexpected: got tgt=%0d addr=%h data=%h, required no transfer",
                 act.tgt, act.addr, act.data);
      end else begin
        exp = sb.pop_front();
        if (act !== exp) begin
          errors++;
          $display("FAIL xfer_order: got tgt=%0d addr=%h data=%h, required tgt=%0d addr=%h data=%h",
                   act.tgt, act.addr, act.data, exp.tgt, exp.addr, exp.data);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk_24);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_24);
  endtask

  task automatic wr_byte(input logic [7:0] idx, input logic [ADDR_W-1:0] a,
                         input logic [7:0] d, input logic [1:0] tgt, input bit stored);
    tick();
    dn_wr = 1'b1; dn_index = idx; dn_addr = a; dn_data = d;
    if (stored) sb.push_back('{tgt: tgt, addr: a, data: d});
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    smp();
    while (busy !== 1'b0 && n < 80) begin
      tick(); smp(); n++;
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_timeout: got busy=%b after %0d cycles, required 0", name, busy, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    smp();
    checks++;
    if ({bios_wr, sprite_wr, music_wr} !== 3'b000) begin
      errors++; $display("FAIL reset_wr: got %b%b%b, required 000", bios_wr, sprite_wr, music_wr);
    end
    checks++;
    if ({bios_addr, sprite_addr, music_addr} !== '0) begin
      errors++; $display("FAIL reset_addr: got %h %h %h, required 0", bios_addr, sprite_addr, music_addr);
    end
    checks++;
    if ({bios_data, sprite_data, music_data} !== '0) begin
      errors++; $display("FAIL reset_data: got %h %h %h, required 0", bios_data, sprite_data, music_data);
    end
    checks++;
    if ({core_reset, busy, overflow} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got core_reset/busy/overflow=%b%b%b, required 000",
                         core_reset, busy, overflow);
    end
    checks++;
    if (dropped !== 8'd0) begin
      errors++; $display("FAIL reset_dropped: got %0d, required 0", dropped);
    end
  endtask

  task automatic test_bios_load();
    bios_ready = 1'b1;
    tick();
    dn_download = 1'b1; dn_index = 8'd0;
    smp();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL bios_busy_edge: got %b, required 0 in edge cycle", busy);
    end
    for (int i = 0; i < 5; i++) begin
      wr_byte(8'd0, ADDR_W'(i), 8'hA0 + 8'(i), 2'd0, 1'b1);
      smp();
      checks++;
      if (bios_wr !== (i != 0)) begin
        errors++; $display("FAIL bios_latency_%0d: got bios_wr=%b, required %b", i, bios_wr, (i != 0));
      end
      if (i == 0) begin
        checks++;
        if ({core_reset, busy} !== 2'b11) begin
          errors++; $display("FAIL bios_start: got core_reset/busy=%b%b, required 11", core_reset, busy);
        end
      end
    end
    tick();
    dn_wr = 1'b0; dn_download = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) tick();
      smp();
      if (k < 2) begin
        checks++;
        if (bios_wr !== (k == 0)) begin
          errors++; $display("FAIL bios_last_%0d: got bios_wr=%b, required %b", k, bios_wr, (k == 0));
        end
      end
      checks++;
      if ({core_reset, busy} !== {2{k <= 17}}) begin
        errors++;
        $display("FAIL bios_tail_%0d: got core_reset/busy=%b%b, required %b%b",
                 k, core_reset, busy, (k <= 17), (k <= 17));
      end
    end
    checks++;
    if (xfer_cnt[0] !== 5 || sb.size() != 0) begin
      errors++; $display("FAIL bios_count: got %0d transfers, %0d pending, required 5 and 0",
                         xfer_cnt[0], sb.size());
    end
  endtask

  task automatic test_backpressure();
    int base;
    sprite_ready = 1'b0;
    tick();
    dn_download = 1'b1; dn_index = 8'd3;
    for (int i = 0; i < 4; i++) wr_byte(8'd3, ADDR_W'(17'h100 + i), 8'hB0 + 8'(i), 2'd1, 1'b1);
    tick();
    dn_wr = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (j > 0) tick();
      smp();
      checks++;
      if ({sprite_wr, sprite_addr, sprite_data, overflow} !== {1'b1, 17'h100, 8'hB0, 1'b0}) begin
        errors++;
        $display("FAIL bp_stall_%0d: got wr=%b addr=%h data=%h ovf=%b, required 1 00100 b0 0",
                 j, sprite_wr, sprite_addr, sprite_data, overflow);
      end
    end
    wr_byte(8'd3, 17'h1FF, 8'hEE, 2'd1, 1'b0);
    tick();
    dn_wr = 1'b0;
    smp();
    checks++;
    if ({overflow, sprite_addr} !== {1'b1, 17'h100}) begin
      errors++; $display("FAIL bp_overflow: got ovf=%b head=%h, required 1 00100", overflow, sprite_addr);
    end
    base = xfer_cnt[1];
    tick();
    sprite_ready = 1'b1; dn_download = 1'b0;
    repeat (8) tick();
    smp();
    checks++;
    if (xfer_cnt[1] - base != 4 || sb.size() != 0) begin
      errors++; $display("FAIL bp_delivered: got %0d, required 4", xfer_cnt[1] - base);
    end
    wait_idle("bp");
  endtask

  task automatic test_full_simul();
    int base;
    base = xfer_cnt[1];
    sprite_ready = 1'b0;
    tick();
    dn_download = 1'b1; dn_index = 8'd3;
    for (int i = 0; i < 4; i++) begin
      wr_byte(8'd3, ADDR_W'(17'h200 + i), 8'hC0 + 8'(i), 2'd1, 1'b1);
      if (i == 0) begin
        smp();
        checks++;
        if (overflow !== 1'b0) begin
          errors++; $display("FAIL full_ovf_clear: got %b, required 0 after new download", overflow);
        end
      end
    end
    wr_byte(8'd3, 17'h204, 8'hC4, 2'd1, 1'b1);
    sprite_ready = 1'b1;
    tick();
    dn_wr = 1'b0;
    smp();
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL full_simul_ovf: got %b, required 0", overflow);
    end
    tick();
    dn_download = 1'b0;
    repeat (6) tick();
    smp();
    checks++;
    if (xfer_cnt[1] - base != 5 || sb.size() != 0) begin
      errors++; $display("FAIL full_simul_delivered: got %0d, required 5", xfer_cnt[1] - base);
    end
    wait_idle("full");
  endtask

  task automatic test_unmapped();
    int base;
    base = xfer_total;
    cr_seen = 1'b0;
    tick();
    dn_download = 1'b1; dn_index = 8'd2;
    for (int i = 0; i < 3; i++) wr_byte(8'd2, ADDR_W'(i), 8'(i), 2'd0, 1'b0);
    tick();
    dn_wr = 1'b0; dn_download = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(); dn_wr = 1'b1;
    end
    tick();
    dn_wr = 1'b0;
    smp();
    checks++;
    if (dropped !== 8'd5) begin
      errors++; $display("FAIL unmapped_dropped: got %0d, required 5", dropped);
    end
    checks++;
    if (xfer_total != base || cr_seen !== 1'b0) begin
      errors++; $display("FAIL unmapped_side: got %0d transfers core_reset_seen=%b, required 0 and 0",
                         xfer_total - base, cr_seen);
    end
    for (int i = 0; i < 249; i++) begin
      tick(); dn_wr = 1'b1;
    end
    tick();
    dn_wr = 1'b0;
    smp();
    checks++;
    if (dropped !== 8'd254) begin
      errors++; $display("FAIL dropped_pre_sat: got %0d, required 254", dropped);
    end
    for (int i = 0; i < 51; i++) begin
      tick(); dn_wr = 1'b1;
    end
    tick();
    dn_wr = 1'b0;
    smp();
    checks++;
    if (dropped !== 8'd255) begin
      errors++; $display("FAIL dropped_sat: got %0d, required 255", dropped);
    end
    wait_idle("unmapped");
  endtask

  task automatic test_mixed_order();
    int base;
    music_ready = 1'b0; bios_ready = 1'b1;
    tick();
    dn_download = 1'b1; dn_index = 8'd4;
    wr_byte(8'd4, 17'h007, 8'h77, 2'd2, 1'b1);
    wr_byte(8'd0, 17'h008, 8'h88, 2'd0, 1'b1);
    tick();
    dn_wr = 1'b0;
    for (int j = 0; j < 5; j++) begin
      if (j > 0) tick();
      smp();
      checks++;
      if ({bios_wr, music_wr} !== 2'b01) begin
        errors++; $display("FAIL mixed_block_%0d: got bios_wr/music_wr=%b%b, required 01",
                           j, bios_wr, music_wr);
      end
    end
    base = xfer_cnt[0];
    tick();
    music_ready = 1'b1;
    repeat (3) tick();
    smp();
    checks++;
    if (xfer_cnt[0] - base != 1 || sb.size() != 0) begin
      errors++; $display("FAIL mixed_delivered: got %0d bios, %0d pending, required 1 and 0",
                         xfer_cnt[0] - base, sb.size());
    end
    tick();
    dn_download = 1'b0;
    wait_idle("mixed");
  endtask

  task automatic test_reset_mid();
    int base;
    bios_ready = 1'b0;
    tick();
    dn_download = 1'b1; dn_index = 8'd0;
    for (int i = 0; i < 3; i++) wr_byte(8'd0, ADDR_W'(17'h300 + i), 8'hD0 + 8'(i), 2'd0, 1'b1);
    tick();
    dn_wr = 1'b0;
    smp();
    checks++;
    if ({bios_wr, core_reset, busy} !== 3'b111) begin
      errors++; $display("FAIL rmid_pre: got wr/core_reset/busy=%b%b%b, required 111",
                         bios_wr, core_reset, busy);
    end
    tick();
    reset = 1'b1; dn_download = 1'b0;
    sb.delete();
    base = xfer_total;
    tick();
    reset = 1'b0; bios_ready = 1'b1;
    smp();
    checks++;
    if ({bios_wr, sprite_wr, music_wr, busy, core_reset} !== 5'b00000) begin
      errors++; $display("FAIL rmid_after: got wr=%b%b%b busy=%b core_reset=%b, required all 0",
                         bios_wr, sprite_wr, music_wr, busy, core_reset);
    end
    repeat (4) tick();
    smp();
    checks++;
    if (bios_wr !== 1'b0 || xfer_total != base) begin
      errors++; $display("FAIL rmid_flushed: got bios_wr=%b transfers=%0d, required 0 and 0",
                         bios_wr, xfer_total - base);
    end
  endtask

  initial begin
    test_reset();
    test_bios_load();
    test_backpressure();
    test_full_simul();
    test_unmapped();
    test_mixed_order();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_leftover: got %0d pending, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation did not complete, required completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
